// File: rtl/fixed_gqa_kv_replay.sv
// Replays one grouped K^T/V tile stream GROUP_SIZE times: pass 0 is a zero-latency
// pass-through that captures tiles into a buffer, later passes are read back from it.
module fixed_gqa_kv_replay #(
  parameter int DATA_WIDTH = 16,
  parameter int DIM0       = 4,
  parameter int DIM1       = 4,
  parameter int NUM_TILES  = 16,
  parameter int GROUP_SIZE = 4,
  localparam int PTR_W  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
  localparam int HEAD_W = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1,
  localparam int TILE_W = DATA_WIDTH * DIM0 * DIM1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TILE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [TILE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HEAD_W-1:0] out_head,
  output logic              out_last
);

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] PRIME  = 2'd1;
  localparam logic [1:0] REPLAY = 2'd2;

  localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(NUM_TILES - 1);
  localparam logic [HEAD_W-1:0] LAST_PASS  = HEAD_W'(GROUP_SIZE - 1);
  localparam logic [PTR_W-1:0]  PTR_AFTER0 = (NUM_TILES == 1) ? '0 : PTR_W'(1);

  logic [1:0]        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_inc;
  logic [HEAD_W-1:0] pass;
  logic [TILE_W-1:0] out_reg;
  logic [TILE_W-1:0] tile_mem [NUM_TILES];
  logic              mem_we;
  logic              reg_load;
  logic [PTR_W-1:0]  rd_ptr;

  assign ptr_inc = (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = out_reg;
    out_head  = '0;
    out_last  = 1'b0;
    if (!rst) begin
      case (state)
        FILL: begin
          out_data  = in_data;
          out_valid = in_valid;
          in_ready  = out_ready;
          out_last  = (GROUP_SIZE == 1) && (ptr == LAST_PTR);
        end
        REPLAY: begin
          out_valid = 1'b1;
          out_head  = pass;
          // ptr already points one past the displayed tile, so ptr==0 means tile NUM_TILES-1
          out_last  = (pass == LAST_PASS) && (ptr == '0);
        end
        default: ;
      endcase
    end
  end

  assign mem_we   = !rst && (state == FILL) && in_valid && out_ready;
  assign reg_load = !rst && ((state == PRIME) || ((state == REPLAY) && out_ready));
  assign rd_ptr   = (state == PRIME) ? '0 : ptr;

  // Buffer and output register are data-only; reset leaves them untouched.
  always_ff @(posedge clk) begin
    if (mem_we) tile_mem[ptr] <= in_data;
    if (reg_load) out_reg <= tile_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      ptr   <= '0;
      pass  <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid && out_ready) begin
            ptr <= ptr_inc;
            if ((ptr == LAST_PTR) && (GROUP_SIZE > 1)) begin
              state <= PRIME;
              pass  <= HEAD_W'(1);
            end
          end
        end
        PRIME: begin
          ptr   <= PTR_AFTER0;
          state <= REPLAY;
        end
        REPLAY: begin
          if (out_ready) begin
            ptr <= ptr_inc;
            if (ptr == '0) begin
              if (pass == LAST_PASS) begin
                state <= FILL;
                ptr   <= '0;
                pass  <= '0;
              end else begin
                pass <= pass + HEAD_W'(1);
              end
            end
          end
        end
        default: begin
          state <= FILL;
          ptr   <= '0;
          pass  <= '0;
        end
      endcase
    end
  end

endmodule
